// File: rtl/inst_fetch_resp_pkg.sv
// Shared fetch-path constants: enable/stall polarities, bus widths and FSM encodings.
package inst_fetch_resp_pkg;

  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;
  localparam logic STOP         = 1'b1;
  localparam logic NO_STOP      = 1'b0;

  localparam int INST_ADDR_W = 32;
  localparam int INST_BUS_W  = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/inst_fetch_resp_if.sv
// Fetch request/response plus byte-wide memory read bus between PC stage and fetch responder.
interface inst_fetch_resp_if
  import inst_fetch_resp_pkg::*;
#(
  parameter int ADDR_W = INST_ADDR_W,
  parameter int INST_W = INST_BUS_W
);
  logic              ce;
  logic [ADDR_W-1:0] pc;
  logic              flush_i;
  logic [INST_W-1:0] inst_o;
  logic              inst_valid_o;
  logic              stallreq_o;
  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [7:0]        mem_rdata_i;
  logic              mem_rvalid_i;

  modport master (
    output ce, pc, flush_i, mem_rdata_i, mem_rvalid_i,
    input  inst_o, inst_valid_o, stallreq_o, mem_req_o, mem_addr_o
  );

  modport slave (
    input  ce, pc, flush_i, mem_rdata_i, mem_rvalid_i,
    output inst_o, inst_valid_o, stallreq_o, mem_req_o, mem_addr_o
  );
endinterface

// File: rtl/inst_fetch_resp.sv
// Instruction fetch responder: assembles a word from four byte reads, stalls the pipe
// while busy, and serves repeated fetches of the last word from a one-entry buffer.
module inst_fetch_resp
  import inst_fetch_resp_pkg::*;
#(
  parameter int ADDR_W = INST_ADDR_W,
  parameter int INST_W = INST_BUS_W
) (
  input  logic               clk,
  input  logic               rst,
  inst_fetch_resp_if.slave   bus
);

  fetch_state_t      state;
  logic              buf_valid;
  logic [ADDR_W-1:2] buf_tag;
  logic [INST_W-1:0] buf_data;
  logic [ADDR_W-1:2] lat_tag;
  logic [1:0]        beat;
  logic [23:0]       asm_q;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;

  logic              hit;
  logic [ADDR_W-1:0] word_addr;

  assign word_addr = bus.pc & {{(ADDR_W-2){1'b1}}, 2'b00};
  assign hit       = (bus.ce == CHIP_ENABLE) && buf_valid && (buf_tag == bus.pc[ADDR_W-1:2]);

  // Outputs are forced quiet during reset so the pipe never sees a stale buffer.
  assign bus.inst_o       = rst ? '0 : buf_data;
  assign bus.inst_valid_o = !rst && hit && (state == ST_IDLE);
  assign bus.stallreq_o   = (!rst && ((state != ST_IDLE) || ((bus.ce == CHIP_ENABLE) && !hit)))
                            ? STOP : NO_STOP;
  assign bus.mem_req_o    = mem_req;
  assign bus.mem_addr_o   = mem_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      buf_valid <= 1'b0;
      buf_tag   <= '0;
      buf_data  <= '0;
      lat_tag   <= '0;
      beat      <= 2'd0;
      asm_q     <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if ((bus.ce == CHIP_ENABLE) && !hit && !bus.flush_i) begin
            lat_tag  <= word_addr[ADDR_W-1:2];
            mem_req  <= 1'b1;
            mem_addr <= word_addr;
            beat     <= 2'd0;
            state    <= ST_FETCH;
          end
        end

        ST_FETCH: begin
          if (bus.flush_i) begin
            // A read still in flight must be retired in DRAIN before the bus goes idle.
            if (bus.mem_rvalid_i) begin
              mem_req <= 1'b0;
              state   <= ST_IDLE;
            end else begin
              state   <= ST_DRAIN;
            end
          end else if (bus.mem_rvalid_i) begin
            if (beat == 2'd3) begin
              buf_data  <= {bus.mem_rdata_i, asm_q};
              buf_tag   <= lat_tag;
              buf_valid <= 1'b1;
              mem_req   <= 1'b0;
              state     <= ST_IDLE;
            end else begin
              case (beat)
                2'd0:    asm_q[7:0]   <= bus.mem_rdata_i;
                2'd1:    asm_q[15:8]  <= bus.mem_rdata_i;
                default: asm_q[23:16] <= bus.mem_rdata_i;
              endcase
              beat     <= beat + 2'd1;
              mem_addr <= mem_addr + 1'b1;
            end
          end
        end

        ST_DRAIN: begin
          if (bus.mem_rvalid_i) begin
            mem_req <= 1'b0;
            state   <= ST_IDLE;
          end
        end

        default: begin
          mem_req <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_resp.sv
// Scenario bench for inst_fetch_resp: byte-memory responder with configurable wait
// states, an address scoreboard for accepted beats, and per-scenario timing checks.
module tb_inst_fetch_resp;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inst_fetch_resp_if bus();

  inst_fetch_resp dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_a;
  bit          mon_en    = 1'b0;
  bit          resp_hold = 1'b0;
  int          wait_cycles = 0;
  int          wcnt = 0;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'h0: return 8'h13;
      32'h1: return 8'h05;
      32'h2: return 8'h10;
      32'h3: return 8'h00;
      default: return (a[7:0] ^ 8'h5A) + a[31:24];
    endcase
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
  endfunction

  // Memory model: after wait_cycles idle cycles per byte, present the byte at mem_addr_o.
  initial begin
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (rst || !bus.mem_req_o || resp_hold) begin
        bus.mem_rvalid_i = 1'b0;
        wcnt = 0;
      end else begin
        if (bus.mem_rvalid_i) wcnt = 0;
        if (wcnt >= wait_cycles) begin
          bus.mem_rvalid_i = 1'b1;
          bus.mem_rdata_i  = mem_byte(bus.mem_addr_o);
        end else begin
          bus.mem_rvalid_i = 1'b0;
          wcnt++;
        end
      end
    end
  end

  // Scoreboard: every beat the DUT accepts must match the next expected byte address.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (mon_en && !rst && bus.mem_req_o && bus.mem_rvalid_i && !bus.flush_i) begin
        checks++;
        if (exp_addr_q.size() == 0) begin
          failures++;
          $display("FAIL beat_addr: unexpected beat at addr %h, none expected", bus.mem_addr_o);
        end else begin
          exp_a = exp_addr_q.pop_front();
          if (bus.mem_addr_o !== exp_a) begin
            failures++;
            $display("FAIL beat_addr: got %h expected %h", bus.mem_addr_o, exp_a);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_valid(output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      #1;
      cnt++;
    end while (!bus.inst_valid_o && cnt < 60);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.ce = 1'b1;
    bus.pc = 32'h0;
    bus.flush_i = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus.stallreq_o !== 1'b0) begin failures++; $display("FAIL rst_stall: got %b expected 0", bus.stallreq_o); end
    checks++; if (bus.inst_valid_o !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b expected 0", bus.inst_valid_o); end
    checks++; if (bus.inst_o !== 32'h0) begin failures++; $display("FAIL rst_inst: got %h expected 0", bus.inst_o); end
    checks++; if (bus.mem_req_o !== 1'b0) begin failures++; $display("FAIL rst_req: got %b expected 0", bus.mem_req_o); end
    checks++; if (bus.mem_addr_o !== 32'h0) begin failures++; $display("FAIL rst_addr: got %h expected 0", bus.mem_addr_o); end
    @(negedge clk);
    rst = 1'b0;
    bus.ce = 1'b0;
  endtask

  task automatic test_miss_zero_wait();
    int cnt;
    @(negedge clk);
    wait_cycles = 0;
    for (int i = 0; i < 4; i++) exp_addr_q.push_back(32'(i));
    mon_en = 1'b1;
    bus.ce = 1'b1;
    bus.pc = 32'h0;
    #1;
    checks++; if (bus.stallreq_o !== 1'b1) begin failures++; $display("FAIL miss_stall_t0: got %b expected 1", bus.stallreq_o); end
    checks++; if (bus.mem_req_o !== 1'b0) begin failures++; $display("FAIL miss_req_t0: got %b expected 0", bus.mem_req_o); end
    wait_valid(cnt);
    checks++; if (cnt !== 5) begin failures++; $display("FAIL miss0_latency: got %0d expected 5", cnt); end
    checks++; if (bus.inst_o !== 32'h0010_0513) begin failures++; $display("FAIL miss0_inst: got %h expected 00100513", bus.inst_o); end
    checks++; if (bus.stallreq_o !== 1'b0) begin failures++; $display("FAIL miss0_stall_done: got %b expected 0", bus.stallreq_o); end
    checks++; if (exp_addr_q.size() !== 0) begin failures++; $display("FAIL miss0_beats: %0d beats missing, expected 0", exp_addr_q.size()); end
  endtask

  task automatic test_hit();
    bit req_seen = 1'b0;
    @(negedge clk);
    bus.ce = 1'b0;
    #1;
    checks++; if (bus.stallreq_o !== 1'b0 || bus.inst_valid_o !== 1'b0) begin failures++; $display("FAIL ce_off: stall=%b valid=%b expected 0 0", bus.stallreq_o, bus.inst_valid_o); end
    @(negedge clk);
    bus.ce = 1'b1;
    bus.pc = 32'h2;
    #1;
    checks++; if (bus.inst_valid_o !== 1'b1) begin failures++; $display("FAIL hit_valid: got %b expected 1", bus.inst_valid_o); end
    checks++; if (bus.stallreq_o !== 1'b0) begin failures++; $display("FAIL hit_stall: got %b expected 0", bus.stallreq_o); end
    checks++; if (bus.inst_o !== 32'h0010_0513) begin failures++; $display("FAIL hit_inst: got %h expected 00100513", bus.inst_o); end
    repeat (4) begin
      @(negedge clk);
      #1;
      if (bus.mem_req_o) req_seen = 1'b1;
    end
    checks++; if (req_seen !== 1'b0) begin failures++; $display("FAIL hit_no_req: req seen=%b expected 0", req_seen); end
  endtask

  task automatic test_wait2();
    int cnt;
    @(negedge clk);
    wait_cycles = 2;
    for (int i = 4; i < 8; i++) exp_addr_q.push_back(32'(i));
    bus.pc = 32'h4;
    #1;
    checks++; if (bus.stallreq_o !== 1'b1) begin failures++; $display("FAIL wait2_stall: got %b expected 1", bus.stallreq_o); end
    wait_valid(cnt);
    checks++; if (cnt !== 13) begin failures++; $display("FAIL wait2_latency: got %0d expected 13", cnt); end
    checks++; if (bus.inst_o !== mem_word(32'h4)) begin failures++; $display("FAIL wait2_inst: got %h expected %h", bus.inst_o, mem_word(32'h4)); end
    checks++; if (exp_addr_q.size() !== 0) begin failures++; $display("FAIL wait2_beats: %0d beats missing, expected 0", exp_addr_q.size()); end
    @(negedge clk);
    bus.ce = 1'b0;
  endtask

  task automatic test_flush_drain();
    int cnt;
    bit held = 1'b1;
    @(negedge clk);
    wait_cycles = 0;
    exp_addr_q.push_back(32'h8);
    exp_addr_q.push_back(32'h9);
    bus.ce = 1'b1;
    bus.pc = 32'h8;
    @(negedge clk);
    @(negedge clk);
    resp_hold = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (bus.mem_addr_o !== 32'hA || bus.mem_req_o !== 1'b1) begin failures++; $display("FAIL flush_beat2: addr=%h req=%b expected 0000000a 1", bus.mem_addr_o, bus.mem_req_o); end
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
    bus.ce = 1'b0;
    mon_en = 1'b0;
    #1;
    checks++; if (exp_addr_q.size() !== 0) begin failures++; $display("FAIL flush_beats: %0d beats missing, expected 0", exp_addr_q.size()); end
    repeat (3) begin
      @(negedge clk);
      #1;
      if (!bus.mem_req_o || !bus.stallreq_o) held = 1'b0;
    end
    checks++; if (held !== 1'b1) begin failures++; $display("FAIL drain_hold: req/stall held=%b expected 1", held); end
    @(negedge clk);
    resp_hold = 1'b0;
    cnt = 0;
    do begin
      @(negedge clk);
      #1;
      cnt++;
    end while (bus.mem_req_o && cnt < 20);
    checks++; if (cnt !== 2) begin failures++; $display("FAIL drain_latency: got %0d expected 2", cnt); end
    checks++; if (bus.stallreq_o !== 1'b0 || bus.inst_valid_o !== 1'b0) begin failures++; $display("FAIL drain_idle: stall=%b valid=%b expected 0 0", bus.stallreq_o, bus.inst_valid_o); end
    @(negedge clk);
    bus.ce = 1'b1;
    bus.pc = 32'h4;
    #1;
    checks++; if (bus.inst_valid_o !== 1'b1 || bus.inst_o !== mem_word(32'h4)) begin failures++; $display("FAIL flush_buf_kept: valid=%b inst=%h expected 1 %h", bus.inst_valid_o, bus.inst_o, mem_word(32'h4)); end
    @(negedge clk);
    bus.pc = 32'h8;
    bus.flush_i = 1'b1;
    #1;
    checks++; if (bus.stallreq_o !== 1'b1 || bus.inst_valid_o !== 1'b0) begin failures++; $display("FAIL idle_flush_stall: stall=%b valid=%b expected 1 0", bus.stallreq_o, bus.inst_valid_o); end
    @(negedge clk);
    bus.flush_i = 1'b0;
    bus.ce = 1'b0;
    #1;
    checks++; if (bus.mem_req_o !== 1'b0) begin failures++; $display("FAIL idle_flush_noreq: got %b expected 0", bus.mem_req_o); end
    mon_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    int cnt;
    @(negedge clk);
    wait_cycles = 0;
    exp_addr_q.push_back(32'h20);
    bus.ce = 1'b1;
    bus.pc = 32'h20;
    @(negedge clk);
    #1;
    checks++; if (bus.mem_addr_o !== 32'h20) begin failures++; $display("FAIL rmid_beat0: got %h expected 00000020", bus.mem_addr_o); end
    @(negedge clk);
    mon_en = 1'b0;
    exp_addr_q.delete();
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (bus.mem_req_o !== 1'b0) begin failures++; $display("FAIL rmid_req: got %b expected 0", bus.mem_req_o); end
    checks++; if (bus.stallreq_o !== 1'b0 || bus.inst_valid_o !== 1'b0 || bus.inst_o !== 32'h0) begin failures++; $display("FAIL rmid_outs: stall=%b valid=%b inst=%h expected 0 0 0", bus.stallreq_o, bus.inst_valid_o, bus.inst_o); end
    rst = 1'b0;
    bus.ce = 1'b0;
    @(negedge clk);
    for (int i = 4; i < 8; i++) exp_addr_q.push_back(32'(i));
    mon_en = 1'b1;
    bus.ce = 1'b1;
    bus.pc = 32'h4;
    #1;
    checks++; if (bus.stallreq_o !== 1'b1 || bus.inst_valid_o !== 1'b0) begin failures++; $display("FAIL rmid_miss: stall=%b valid=%b expected 1 0", bus.stallreq_o, bus.inst_valid_o); end
    wait_valid(cnt);
    checks++; if (cnt !== 5 || bus.inst_o !== mem_word(32'h4)) begin failures++; $display("FAIL rmid_refetch: cycles=%0d inst=%h expected 5 %h", cnt, bus.inst_o, mem_word(32'h4)); end
  endtask

  task automatic test_wrap();
    int cnt;
    @(negedge clk);
    wait_cycles = 0;
    for (int i = 0; i < 4; i++) exp_addr_q.push_back(32'hFFFF_FFFC + 32'(i));
    bus.ce = 1'b1;
    bus.pc = 32'hFFFF_FFFC;
    wait_valid(cnt);
    checks++; if (cnt !== 5) begin failures++; $display("FAIL wrap_latency: got %0d expected 5", cnt); end
    checks++; if (bus.inst_o !== mem_word(32'hFFFF_FFFC)) begin failures++; $display("FAIL wrap_inst: got %h expected %h", bus.inst_o, mem_word(32'hFFFF_FFFC)); end
    checks++; if (exp_addr_q.size() !== 0) begin failures++; $display("FAIL wrap_beats: %0d beats missing, expected 0", exp_addr_q.size()); end
  endtask

  task automatic test_back_to_back();
    int cnt;
    @(negedge clk);
    wait_cycles = 1;
    for (int i = 0; i < 4; i++) exp_addr_q.push_back(32'h100 + 32'(i));
    bus.pc = 32'h100;
    wait_valid(cnt);
    checks++; if (cnt !== 9) begin failures++; $display("FAIL b2b_latency: got %0d expected 9", cnt); end
    checks++; if (bus.inst_o !== mem_word(32'h100)) begin failures++; $display("FAIL b2b_inst: got %h expected %h", bus.inst_o, mem_word(32'h100)); end
    checks++; if (exp_addr_q.size() !== 0) begin failures++; $display("FAIL b2b_beats: %0d beats missing, expected 0", exp_addr_q.size()); end
    @(negedge clk);
    bus.ce = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.ce = 1'b0;
    bus.pc = '0;
    bus.flush_i = 1'b0;
    test_reset();
    test_miss_zero_wait();
    test_hit();
    test_wait2();
    test_flush_drain();
    test_reset_mid();
    test_wrap();
    test_back_to_back();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_fetch_resp.md
# inst_fetch_resp

Responder side of the instruction-fetch interface: accepts the fetch address `pc` and chip-enable `ce` driven by the PC register and returns a 32-bit instruction. Each instruction is fetched from the byte-wide memory bus as four 8-bit reads. While a fetch is in flight the block raises `stallreq_o` to the pipeline controller, which holds the PC stable. A one-entry last-instruction buffer returns a repeated fetch of the same word with zero latency.

## Interface
Parameters:
- `ADDR_W`, default 32: fetch/memory address width.
- `INST_W`, default 32: instruction width. Fixed at 4 bytes; other values are unsupported.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: reset, synchronous, active-high.
- `ce`  in  1: fetch enable from the PC register; `ChipEnable` = 1.
- `pc`  in  ADDR_W: fetch address. Bits [1:0] are ignored; the word address is `{pc[ADDR_W-1:2],2'b00}`.
- `flush_i`  in  1: abort the in-flight fetch (branch redirect / exception).
- `inst_o`  out  INST_W: instruction; meaningful only while `inst_valid_o` is high.
- `inst_valid_o`  out  1: `inst_o` corresponds to the current `pc`.
- `stallreq_o`  out  1: fetch-stage stall request to the pipeline controller.
- `mem_req_o`  out  1: byte read request, registered.
- `mem_addr_o`  out  ADDR_W: byte address, registered.
- `mem_rdata_i`  in  8: read byte.
- `mem_rvalid_i`  in  1: `mem_rdata_i` valid. Counts only in a cycle where `mem_req_o` is high.

## Operation
Storage:
- `buf_valid`, `buf_tag[ADDR_W-1:2]`, `buf_data[31:0]`.
- Byte counter `beat[1:0]`.
- Assembly register `asm[23:0]`.

States: IDLE, FETCH, DRAIN.

Hit condition: `hit = ce & buf_valid & (buf_tag == pc[ADDR_W-1:2])`.

Combinational outputs:
- `inst_valid_o = hit & (state == IDLE)`.
- `inst_o = buf_data`.
- `stallreq_o = (state != IDLE) | (ce & ~hit)`.

Transitions:
- IDLE, with `ce & ~hit & ~flush_i`:
  - latch the word address;
  - set `mem_req_o`=1 and `mem_addr_o`=word address;
  - set `beat`=0;
  - go to FETCH.
- FETCH, with `mem_rvalid_i` and no flush:
  - store the byte little-endian (beat k gives inst[8k+7:8k]);
  - if `beat`<3: increment `beat` and `mem_addr_o`; `mem_req_o` stays high.
  - if `beat`=3: write `buf_data` = {rdata, asm}, set `buf_tag` to the latched address, set `buf_valid`=1, drop `mem_req_o`, go to IDLE.
- FETCH, with `flush_i`:
  - if `mem_rvalid_i` is also high that cycle, the beat is discarded and the next state is IDLE;
  - otherwise go to DRAIN with `mem_req_o` held high, because the outstanding read must complete.
  - In both cases `buf_valid` and `buf_tag` are unchanged.
- DRAIN: wait for `mem_rvalid_i`, discard the data, drop `mem_req_o`, go to IDLE.
- `flush_i` in IDLE: suppresses starting a new fetch that cycle. `stallreq_o` still follows the formula.

Other rules:
- `ce`=0 in IDLE: no request; `stallreq_o`=0; `inst_valid_o`=0.
- `pc` changing during FETCH is a protocol violation. The block completes the fetch for the latched address and does not re-check `pc`.
- Address increment wraps modulo 2^ADDR_W. `beat` never exceeds 3.

Reset: state=IDLE, `buf_valid`=0, `beat`=0, `mem_req_o`=0, `mem_addr_o`=0. Reset mid-fetch abandons the fetch immediately; there is no drain. `stallreq_o`=0, `inst_valid_o`=0, and `inst_o`=`buf_data`=0 while in reset.

## Timing
- Miss detected in cycle T: `stallreq_o`=1 in T, combinationally, so the PC holds at the T edge. `mem_req_o`=1 from T+1.
- With `mem_rvalid_i` held high: beats are accepted at T+1..T+4, the buffer is written at the T+4 edge, and `inst_valid_o`=1, `stallreq_o`=0 in T+5. Minimum miss latency is 5 cycles.
- Each memory wait cycle adds one cycle.
- Hit: zero latency, no stall, no memory traffic.
- Flush-to-IDLE takes 1 cycle, plus the outstanding read's latency if the block goes through DRAIN.

## Structure
- `ChipEnable`, `Stop`/`NoStop`, `InstAddrBus` and `InstBus` widths, and the state encodings belong in the shared `defines.v`.
- Single module with no sub-module. The buffer is three registers, not a memory.

## Test plan
- Reset, then `ce`=1, `pc`=0x0000_0000, memory returns bytes 0x13,0x05,0x10,0x00 with zero wait -> `stallreq_o` high for 5 cycles, `mem_addr_o` steps 0..3, then `inst_o`=0x0010_0513 with `inst_valid_o`=1.
- Same `pc` presented again -> `inst_valid_o`=1 in the same cycle, `stallreq_o`=0, `mem_req_o` never rises.
- `pc`=0x0000_0004 with 2 wait cycles per byte -> 4 accepted beats, valid 13 cycles after miss detection, addresses 4..7.
- `flush_i` asserted during beat 2 with `mem_rvalid_i` low -> DRAIN state; the next rvalid is discarded, the block reaches IDLE, the buffer still holds the previous tag, and `stallreq_o` returns to 0 if `ce`=0.
- `rst` asserted during beat 1 -> next cycle `mem_req_o`=0, `buf_valid`=0; a subsequent fetch of the old `pc` misses.
- `pc`=0xFFFF_FFFC -> byte addresses 0xFFFF_FFFC..0xFFFF_FFFF with no wrap into 0 within the word, and correct assembly.
